hamming_checker: RTL and testbench
==================================

Name: hamming_checker

Overview:
Receive-side counterpart of hamming_generator. It accepts a 7-bit Hamming(7,4) codeword and computes the syndrome under the selected parity mode. It corrects any single-bit error and returns the 4-bit data word, an error flag and the error position. The block sits at the link/storage output, where it consumes codewords produced by hamming_generator. It also keeps a saturating count of corrected words.

Parameters:
CNT_W, 8, width of the saturating corrected-error counter.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  start request; sampled only in IDLE.
mode  input  1  parity mode, latched with code_in: 1 = even parity, 0 = odd parity (same meaning as hamming_generator).
code_in  input  7  received codeword.
data_out  output  4  decoded, corrected data.
data_valid  output  1  one-cycle pulse when data_out, err, err_pos are updated.
busy  output  1  high in every state except IDLE.
err  output  1  a nonzero syndrome was found and one bit was flipped.
err_pos  output  3  syndrome value: 1..7 = corrected position, 0 = no error.
err_count  output  CNT_W  number of words with err=1; saturates at all-ones.

Behaviour:
- Bit mapping matches hamming_generator. Index i holds position i+1:
  - code_in[0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
  - d0..d3 are data bits 0..3.
- Syndrome calculation:
  - s1 = xor(pos 1,3,5,7); s2 = xor(pos 2,3,6,7); s4 = xor(pos 4,5,6,7).
  - In odd mode (mode=0), invert each s bit.
  - syndrome = {s4,s2,s1}.
- Reset (async assert, sync-released by the system): state=IDLE; data_out=0, data_valid=0, busy=0, err=0, err_pos=0, err_count=0.
- FSM states:
  - IDLE: if enable=1, latch code_in and mode into internal registers and go to SYND. Otherwise stay.
  - SYND: register the syndrome. Go to CORR.
  - CORR: if syndrome!=0, flip codeword bit (syndrome-1). Register the corrected data nibble, err and err_pos. Go to OUT.
  - OUT: drive data_valid=1 for exactly this cycle. If err=1, increment err_count (no increment when it is all-ones). Go to IDLE.
- Latency: enable sampled at edge N produces data_valid high from edge N+3 to N+4. Minimum initiation interval is 4 cycles.
- enable while busy=1 is ignored. The request is dropped, not queued.
- code_in and mode may change freely after the IDLE capture edge; only latched copies are used.
- data_out, err and err_pos hold their last values until the next OUT update. They do not return to 0 after data_valid falls.
- Double-bit errors are outside Hamming(7,4) capability. They are miscorrected silently; this is accepted behaviour.
- rst_n asserted mid-operation aborts the operation. All outputs take their reset values immediately, and no data_valid is produced for the aborted word.
- err_count clears only on reset.

Decomposition:
- Shared package hamming_pkg holds:
  - Bit-position constants for p1, p2, p4, d0..d3.
  - MODE_EVEN=1 and MODE_ODD=0.
  - The FSM state encoding (IDLE, SYND, CORR, OUT).
- hamming_generator and hamming_checker both import hamming_pkg.
- One sub-module, hamming_syndrome: combinational. Inputs are a 7-bit code and mode; output is the 3-bit syndrome. It is instantiated in the SYND stage.

Test Plan:
1. Reset, then enable with mode=1 and code_in=7'h52 -> 3 edges later: data_valid pulse, data_out=4'b1010, err=0, err_pos=0, err_count=0.
2. mode=0, code_in=7'h59 -> data_out=4'b1010, err=0, err_pos=0.
3. mode=1, code_in=7'h42 (position 5 flipped) -> data_out=4'b1010, err=1, err_pos=5, err_count=1.
4. mode=1, code_in=7'h53 (parity p1 flipped) -> data_out=4'b1010, err=1, err_pos=1, err_count=2.
5. enable pulsed again on the cycle after a capture (busy=1) -> exactly one data_valid pulse results.
6. rst_n pulled low during CORR -> outputs zero immediately, no data_valid. With CNT_W=2 and four error words, err_count sticks at 3.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) generator/checker pair.
// Holds codeword bit positions, parity-mode encodings and the checker FSM
// state type, plus a helper that pulls the data nibble out of a codeword.
package hamming_pkg;

  // Codeword index i carries Hamming position i+1.
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_P4 = 3;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;

  localparam logic MODE_EVEN = 1'b1;
  localparam logic MODE_ODD  = 1'b0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSynd = 2'd1,
    StCorr = 2'd2,
    StOut  = 2'd3
  } state_e;

  function automatic logic [3:0] extract_data(input logic [6:0] code);
    return {code[POS_D3], code[POS_D2], code[POS_D1], code[POS_D0]};
  endfunction

endpackage

// File: rtl/hamming_checker_if.sv
// Request/response bundle for hamming_checker.
//   enable, mode, code_in        : request side (master drives)
//   data_out, data_valid, busy,
//   err, err_pos, err_count      : result side (slave drives)
interface hamming_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             mode;
  logic [6:0]       code_in;
  logic [3:0]       data_out;
  logic             data_valid;
  logic             busy;
  logic             err;
  logic [2:0]       err_pos;
  logic [CNT_W-1:0] err_count;

  modport master (
    output enable, mode, code_in,
    input  data_out, data_valid, busy, err, err_pos, err_count
  );

  modport slave (
    input  enable, mode, code_in,
    output data_out, data_valid, busy, err, err_pos, err_count
  );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming(7,4) syndrome.
//   i_code  : 7-bit received codeword (index i = position i+1)
//   i_mode  : 1 = even parity, 0 = odd parity
//   o_synd  : {s4,s2,s1}; 0 = no error, else erroneous position
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [6:0] i_code,
  input  logic       i_mode,
  output logic [2:0] o_synd
);

  logic [2:0] w_raw;

  always_comb begin
    w_raw[0] = i_code[POS_P1] ^ i_code[POS_D0] ^ i_code[POS_D1] ^ i_code[POS_D3];
    w_raw[1] = i_code[POS_P2] ^ i_code[POS_D0] ^ i_code[POS_D2] ^ i_code[POS_D3];
    w_raw[2] = i_code[POS_P4] ^ i_code[POS_D1] ^ i_code[POS_D2] ^ i_code[POS_D3];
    // A clean odd-parity word checks to all ones, so invert to get 0 = no error.
    o_synd = (i_mode == MODE_ODD) ? ~w_raw : w_raw;
  end

endmodule

// File: rtl/hamming_checker.sv
// Hamming(7,4) receive-side checker/corrector with saturating error count.
// Flow: IDLE (capture) -> SYND (register syndrome) -> CORR (fix bit, register
// result) -> OUT (publish outputs, pulse data_valid, bump counter) -> IDLE.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hamming_checker_if slave (request in, corrected result out)
module hamming_checker
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  hamming_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_next;
  logic [6:0]       r_code;
  logic             r_mode;
  logic [2:0]       r_synd;
  logic [2:0]       w_synd;
  logic [3:0]       r_corr_data;
  logic             r_corr_err;
  logic [2:0]       r_corr_pos;
  logic [6:0]       w_flip;
  logic [6:0]       w_fixed;
  logic [3:0]       r_data_out;
  logic             r_valid;
  logic             r_err;
  logic [2:0]       r_err_pos;
  logic [CNT_W-1:0] r_count;

  hamming_syndrome u_syndrome (
    .i_code (r_code),
    .i_mode (r_mode),
    .o_synd (w_synd)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.enable) w_state_next = StSynd;
      StSynd:  w_state_next = StCorr;
      StCorr:  w_state_next = StOut;
      StOut:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_flip = '0;
    if (r_synd != 3'd0) w_flip = 7'd1 << (r_synd - 3'd1);
    w_fixed = r_code ^ w_flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_code      <= '0;
      r_mode      <= MODE_EVEN;
      r_synd      <= '0;
      r_corr_data <= '0;
      r_corr_err  <= 1'b0;
      r_corr_pos  <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_err_pos   <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_next;
      // Registered pulse: high for the cycle following the OUT state.
      r_valid <= (r_state == StOut);
      unique case (r_state)
        StIdle: begin
          if (bus.enable) begin
            r_code <= bus.code_in;
            r_mode <= bus.mode;
          end
        end
        StSynd: r_synd <= w_synd;
        StCorr: begin
          r_corr_data <= extract_data(w_fixed);
          r_corr_err  <= (r_synd != 3'd0);
          r_corr_pos  <= r_synd;
        end
        StOut: begin
          r_data_out <= r_corr_data;
          r_err      <= r_corr_err;
          r_err_pos  <= r_corr_pos;
          if (r_corr_err && (r_count != CntMax)) r_count <= r_count + CntOne;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_valid;
  assign bus.busy       = (r_state != StIdle);
  assign bus.err        = r_err;
  assign bus.err_pos    = r_err_pos;
  assign bus.err_count  = r_count;

endmodule

// File: tb/tb_hamming_checker.sv
// Directed bench for hamming_checker (CNT_W=2): latency, correction,
// busy-drop, mid-operation reset and counter saturation, with a result
// scoreboard checked whenever data_valid is seen.
module tb_hamming_checker;

  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [3:0] d;
    logic       e;
    logic [2:0] p;
    logic [1:0] c;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   n_valid;
  int   exp_cnt;

  hamming_checker_if #(.CNT_W(CNT_W)) bus ();

  hamming_checker #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder: syndrome as XOR of set positions, odd mode inverts.
  function automatic void model(input logic m, input logic [6:0] c,
                                output logic [3:0] d, output logic e,
                                output logic [2:0] p);
    logic [2:0] s;
    logic [6:0] f;
    s = 3'd0;
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ 3'(i + 1);
    if (!m) s = s ^ 3'b111;
    f = c;
    if (s != 3'd0) f[int'(s) - 1] = ~f[int'(s) - 1];
    d = {f[6], f[5], f[4], f[2]};
    e = (s != 3'd0);
    p = s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.data_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("data_out", 32'(bus.data_out), 32'(x.d));
        check("err", 32'(bus.err), 32'(x.e));
        check("err_pos", 32'(bus.err_pos), 32'(x.p));
        check("err_count", 32'(bus.err_count), 32'(x.c));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic e, input logic [2:0] p);
    exp_t x;
    if (e) exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
    x.d = d;
    x.e = e;
    x.p = p;
    x.c = 2'(exp_cnt);
    sb.push_back(x);
  endtask

  // Issue one word and check the pulse timing (capture edge N -> valid N+3..N+4).
  task automatic launch(input logic m, input logic [6:0] c,
                        input logic [3:0] d, input logic e, input logic [2:0] p);
    bus.enable  = 1'b1;
    bus.mode    = m;
    bus.code_in = c;
    push_exp(d, e, p);
    step();
    bus.enable  = 1'b0;
    bus.mode    = ~m;
    bus.code_in = 7'($urandom);
    check("busy_after_capture", 32'(bus.busy), 32'd1);
    step();
    check("valid_n1", 32'(bus.data_valid), 32'd0);
    step();
    check("valid_n2", 32'(bus.data_valid), 32'd0);
    step();
    check("valid_n3", 32'(bus.data_valid), 32'd1);
    check("busy_n3", 32'(bus.busy), 32'd0);
    step();
    check("valid_n4", 32'(bus.data_valid), 32'd0);
    check("data_hold", 32'(bus.data_out), 32'(d));
  endtask

  initial begin
    logic [3:0] md;
    logic       me;
    logic [2:0] mp;
    int         v0;
    logic [6:0] sat_code [4];
    logic       sat_mode [4];

    n_checks    = 0;
    n_fail      = 0;
    n_valid     = 0;
    exp_cnt     = 0;
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.mode    = 1'b1;
    bus.code_in = '0;

    step();
    step();
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_pos", 32'(bus.err_pos), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    rst_n = 1'b1;
    step();

    launch(1'b1, 7'h52, 4'b1010, 1'b0, 3'd0);
    launch(1'b0, 7'h59, 4'b1010, 1'b0, 3'd0);
    launch(1'b1, 7'h42, 4'b1010, 1'b1, 3'd5);
    launch(1'b1, 7'h53, 4'b1010, 1'b1, 3'd1);

    // enable held into the busy cycle: second request is dropped.
    v0          = n_valid;
    bus.enable  = 1'b1;
    bus.mode    = 1'b1;
    bus.code_in = 7'h42;
    push_exp(4'b1010, 1'b1, 3'd5);
    step();
    step();
    bus.enable  = 1'b0;
    repeat (8) step();
    check("busy_drop_pulses", 32'(n_valid - v0), 32'd1);

    // Reset while in CORR: outputs clear at once, no pulse for the word.
    bus.enable  = 1'b1;
    bus.code_in = 7'h53;
    step();
    bus.enable  = 1'b0;
    step();
    v0    = n_valid;
    rst_n = 1'b0;
    #1;
    check("abort_data_out", 32'(bus.data_out), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    check("abort_err_pos", 32'(bus.err_pos), 32'd0);
    check("abort_err_count", 32'(bus.err_count), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.data_valid), 32'd0);
    step();
    rst_n = 1'b1;
    exp_cnt = 0;
    repeat (6) step();
    check("abort_no_pulse", 32'(n_valid - v0), 32'd0);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);

    // Four single-bit errors: counter saturates at 3.
    sat_code[0] = 7'h52 ^ 7'h04; sat_mode[0] = 1'b1;
    sat_code[1] = 7'h52 ^ 7'h08; sat_mode[1] = 1'b1;
    sat_code[2] = 7'h59 ^ 7'h20; sat_mode[2] = 1'b0;
    sat_code[3] = 7'h59 ^ 7'h40; sat_mode[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      model(sat_mode[k], sat_code[k], md, me, mp);
      launch(sat_mode[k], sat_code[k], md, me, mp);
    end
    check("sat_count", 32'(bus.err_count), 32'd3);

    repeat (2) step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
